// File: rtl/pipe_pkg.sv
// Shared types for the ID/EX pipeline register: packed control bundle and
// the pipeline-control sequencing states.
package pipe_pkg;

    localparam int unsigned CTRL_ALU_OP_W = 4;

    typedef struct packed {
        logic                     reg_write;
        logic                     mem_read;
        logic                     mem_write;
        logic                     in_port_select;
        logic [CTRL_ALU_OP_W-1:0] alu_op;
    } id_ex_ctrl_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } pipe_ctrl_state_e;

    localparam id_ex_ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard check: a load in EX whose destination is
// read by the instruction currently in decode.
module load_use_detector #(
    parameter int unsigned REG_ADDR_W = 3
) (
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] ex_rdest,
    input  logic                  d_valid,
    input  logic [REG_ADDR_W-1:0] d_rsrc,
    input  logic [REG_ADDR_W-1:0] d_rdest,
    input  logic                  d_uses_rsrc,
    input  logic                  d_uses_rdest,
    output logic                  hazard
);

    logic ex_is_load;
    logic src_match;
    logic dst_match;

    always_comb begin
        ex_is_load = ex_valid && ex_mem_read && ex_reg_write;
        src_match  = d_uses_rsrc  && (d_rsrc  == ex_rdest);
        dst_match  = d_uses_rdest && (d_rdest == ex_rdest);
        hazard     = ex_is_load && d_valid && (src_match || dst_match);
    end

endmodule

// File: rtl/id_ex_stage_buffer.sv
// ID/EX pipeline register with load-use bubble insertion, post-branch squash
// and downstream-stall hold; counts inserted bubbles (saturating).
module id_ex_stage_buffer
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned REG_ADDR_W   = 3,
    parameter int unsigned ALU_OP_W     = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  d_valid,
    input  logic [REG_ADDR_W-1:0] d_rsrc,
    input  logic [REG_ADDR_W-1:0] d_rdest,
    input  logic                  d_uses_rsrc,
    input  logic                  d_uses_rdest,
    input  logic [DATA_W-1:0]     d_read_data1,
    input  logic [DATA_W-1:0]     d_read_data2,
    input  logic [DATA_W-1:0]     d_imm,
    input  logic [ALU_OP_W-1:0]   d_alu_op,
    input  logic                  d_reg_write,
    input  logic                  d_mem_read,
    input  logic                  d_mem_write,
    input  logic                  d_in_port_select,
    input  logic [DATA_W-1:0]     d_in_port_value,
    input  logic                  ext_stall,
    input  logic                  branch_taken,
    output logic                  ex_valid,
    output logic [REG_ADDR_W-1:0] ex_rsrc,
    output logic [REG_ADDR_W-1:0] ex_rdest,
    output logic [DATA_W-1:0]     ex_read_data1,
    output logic [DATA_W-1:0]     ex_read_data2,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [ALU_OP_W-1:0]   ex_alu_op,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_in_port_select,
    output logic [DATA_W-1:0]     ex_in_port_value,
    output logic                  fd_stall,
    output logic [15:0]           bubble_count
);

    localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

    pipe_ctrl_state_e      state_q, state_d;
    logic [1:0]            flush_cnt_q, flush_cnt_d;
    logic                  valid_q, valid_d;
    id_ex_ctrl_t           ctrl_q, ctrl_d;
    logic [REG_ADDR_W-1:0] rsrc_q, rsrc_d;
    logic [REG_ADDR_W-1:0] rdest_q, rdest_d;
    logic [DATA_W-1:0]     data1_q, data1_d;
    logic [DATA_W-1:0]     data2_q, data2_d;
    logic [DATA_W-1:0]     imm_q, imm_d;
    logic [DATA_W-1:0]     inval_q, inval_d;
    logic [15:0]           bub_cnt_q, bub_cnt_d;

    logic hazard;
    logic load_bubble;
    logic load_normal;

    load_use_detector #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detector (
        .ex_valid     (valid_q),
        .ex_mem_read  (ctrl_q.mem_read),
        .ex_reg_write (ctrl_q.reg_write),
        .ex_rdest     (rdest_q),
        .d_valid      (d_valid),
        .d_rsrc       (d_rsrc),
        .d_rdest      (d_rdest),
        .d_uses_rsrc  (d_uses_rsrc),
        .d_uses_rdest (d_uses_rdest),
        .hazard       (hazard)
    );

    // A taken branch outranks the hazard, so it also suppresses the decode stall.
    assign fd_stall = ext_stall || ((state_q == RUN) && hazard && !branch_taken);

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        load_bubble = 1'b0;
        load_normal = 1'b0;

        if (!ext_stall) begin
            case (state_q)
                RUN: begin
                    if (branch_taken) begin
                        load_bubble = 1'b1;
                        flush_cnt_d = FLUSH_RELOAD;
                        state_d     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                    end else if (hazard) begin
                        load_bubble = 1'b1;
                    end else begin
                        load_normal = 1'b1;
                    end
                end
                FLUSH: begin
                    // Counter holds bubbles still owed; leave once the last is loaded.
                    load_bubble = 1'b1;
                    if (flush_cnt_q <= 2'd1) begin
                        flush_cnt_d = '0;
                        state_d     = RUN;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 2'd1;
                    end
                end
                default: begin
                    load_bubble = 1'b1;
                    state_d     = RUN;
                    flush_cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        rsrc_d    = rsrc_q;
        rdest_d   = rdest_q;
        data1_d   = data1_q;
        data2_d   = data2_q;
        imm_d     = imm_q;
        inval_d   = inval_q;
        bub_cnt_d = bub_cnt_q;

        if (load_bubble) begin
            valid_d = 1'b0;
            ctrl_d  = BUBBLE_CTRL;
            rsrc_d  = '0;
            rdest_d = '0;
            data1_d = '0;
            data2_d = '0;
            imm_d   = '0;
            inval_d = '0;
            if (bub_cnt_q != 16'hFFFF) begin
                bub_cnt_d = bub_cnt_q + 16'd1;
            end
        end else if (load_normal) begin
            valid_d               = d_valid;
            ctrl_d.reg_write      = d_reg_write;
            ctrl_d.mem_read       = d_mem_read;
            ctrl_d.mem_write      = d_mem_write;
            ctrl_d.in_port_select = d_in_port_select;
            ctrl_d.alu_op         = CTRL_ALU_OP_W'(d_alu_op);
            rsrc_d                = d_rsrc;
            rdest_d               = d_rdest;
            data1_d               = d_read_data1;
            data2_d               = d_read_data2;
            imm_d                 = d_imm;
            inval_d               = d_in_port_value;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
            valid_q     <= 1'b0;
            ctrl_q      <= BUBBLE_CTRL;
            rsrc_q      <= '0;
            rdest_q     <= '0;
            data1_q     <= '0;
            data2_q     <= '0;
            imm_q       <= '0;
            inval_q     <= '0;
            bub_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            valid_q     <= valid_d;
            ctrl_q      <= ctrl_d;
            rsrc_q      <= rsrc_d;
            rdest_q     <= rdest_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
            imm_q       <= imm_d;
            inval_q     <= inval_d;
            bub_cnt_q   <= bub_cnt_d;
        end
    end

    assign ex_valid          = valid_q;
    assign ex_rsrc           = rsrc_q;
    assign ex_rdest          = rdest_q;
    assign ex_read_data1     = data1_q;
    assign ex_read_data2     = data2_q;
    assign ex_imm            = imm_q;
    assign ex_alu_op         = ALU_OP_W'(ctrl_q.alu_op);
    assign ex_reg_write      = ctrl_q.reg_write;
    assign ex_mem_read       = ctrl_q.mem_read;
    assign ex_mem_write      = ctrl_q.mem_write;
    assign ex_in_port_select = ctrl_q.in_port_select;
    assign ex_in_port_value  = inval_q;
    assign bubble_count      = bub_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_buffer.sv
// Directed bench for id_ex_stage_buffer: reset, load-use bubble, branch
// squash, stall hold, reset mid-flush and bubble-count saturation.
module tb_id_ex_stage_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_valid;
    logic [2:0]  d_rsrc, d_rdest;
    logic        d_uses_rsrc, d_uses_rdest;
    logic [15:0] d_read_data1, d_read_data2, d_imm, d_in_port_value;
    logic [3:0]  d_alu_op;
    logic        d_reg_write, d_mem_read, d_mem_write, d_in_port_select;
    logic        ext_stall, branch_taken;
    logic        ex_valid;
    logic [2:0]  ex_rsrc, ex_rdest;
    logic [15:0] ex_read_data1, ex_read_data2, ex_imm, ex_in_port_value;
    logic [3:0]  ex_alu_op;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_in_port_select;
    logic        fd_stall;
    logic [15:0] bubble_count;

    int n_checks = 0;
    int n_fails  = 0;

    id_ex_stage_buffer #(
        .DATA_W       (16),
        .REG_ADDR_W   (3),
        .ALU_OP_W     (4),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .d_valid           (d_valid),
        .d_rsrc            (d_rsrc),
        .d_rdest           (d_rdest),
        .d_uses_rsrc       (d_uses_rsrc),
        .d_uses_rdest      (d_uses_rdest),
        .d_read_data1      (d_read_data1),
        .d_read_data2      (d_read_data2),
        .d_imm             (d_imm),
        .d_alu_op          (d_alu_op),
        .d_reg_write       (d_reg_write),
        .d_mem_read        (d_mem_read),
        .d_mem_write       (d_mem_write),
        .d_in_port_select  (d_in_port_select),
        .d_in_port_value   (d_in_port_value),
        .ext_stall         (ext_stall),
        .branch_taken      (branch_taken),
        .ex_valid          (ex_valid),
        .ex_rsrc           (ex_rsrc),
        .ex_rdest          (ex_rdest),
        .ex_read_data1     (ex_read_data1),
        .ex_read_data2     (ex_read_data2),
        .ex_imm            (ex_imm),
        .ex_alu_op         (ex_alu_op),
        .ex_reg_write      (ex_reg_write),
        .ex_mem_read       (ex_mem_read),
        .ex_mem_write      (ex_mem_write),
        .ex_in_port_select (ex_in_port_select),
        .ex_in_port_value  (ex_in_port_value),
        .fd_stall          (fd_stall),
        .bubble_count      (bubble_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic valid, input logic [2:0] rs, input logic [2:0] rd,
                           input logic urs, input logic urd, input logic [15:0] dat1,
                           input logic rw, input logic mr, input logic ips,
                           input logic [15:0] inval);
        d_valid          = valid;
        d_rsrc           = rs;
        d_rdest          = rd;
        d_uses_rsrc      = urs;
        d_uses_rdest     = urd;
        d_read_data1     = dat1;
        d_read_data2     = dat1 ^ 16'h00FF;
        d_imm            = 16'h0005;
        d_alu_op         = 4'h4;
        d_reg_write      = rw;
        d_mem_read       = mr;
        d_mem_write      = 1'b0;
        d_in_port_select = ips;
        d_in_port_value  = inval;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
        chk({tag, "_ctrl"}, {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_in_port_select}, 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        ext_stall    = 1'b0;
        branch_taken = 1'b0;
        present(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        #2;
        chk_bubble("reset");
        chk("reset_data1", {16'd0, ex_read_data1}, 32'd0);
        chk("reset_count", {16'd0, bubble_count}, 32'd0);
        chk("reset_fd_stall", {31'd0, fd_stall}, 32'd0);
        #10;
        rst = 1'b0;

        // Load A: ld r3
        present(1'b1, 3'd1, 3'd3, 1'b0, 1'b0, 16'h1111, 1'b1, 1'b1, 1'b0, 16'h0);
        step();
        chk("load_valid", {31'd0, ex_valid}, 32'd1);
        chk("load_rdest", {29'd0, ex_rdest}, 32'd3);
        chk("load_data1", {16'd0, ex_read_data1}, 32'h1111);
        chk("load_data2", {16'd0, ex_read_data2}, 32'h11EE);
        chk("load_memrd", {31'd0, ex_mem_read}, 32'd1);
        chk("load_aluop", {28'd0, ex_alu_op}, 32'h4);

        // B reads r3 as rsrc: load-use
        present(1'b1, 3'd3, 3'd5, 1'b1, 1'b0, 16'hAAAA, 1'b1, 1'b0, 1'b0, 16'h0);
        #1;
        chk("lu_fd_stall", {31'd0, fd_stall}, 32'd1);
        step();
        chk_bubble("lu_bubble");
        chk("lu_count", {16'd0, bubble_count}, 32'd1);
        chk("lu_fd_release", {31'd0, fd_stall}, 32'd0);
        step();
        chk("lu_reload_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_reload_rdest", {29'd0, ex_rdest}, 32'd5);
        chk("lu_reload_rsrc", {29'd0, ex_rsrc}, 32'd3);
        chk("lu_reload_data1", {16'd0, ex_read_data1}, 32'hAAAA);

        // Load A again, then C names r3 but reads no register
        present(1'b1, 3'd1, 3'd3, 1'b0, 1'b0, 16'h1111, 1'b1, 1'b1, 1'b0, 16'h0);
        step();
        present(1'b1, 3'd3, 3'd3, 1'b0, 1'b0, 16'hCCCC, 1'b1, 1'b0, 1'b1, 16'hBEEF);
        #1;
        chk("nouse_fd_stall", {31'd0, fd_stall}, 32'd0);
        step();
        chk("nouse_valid", {31'd0, ex_valid}, 32'd1);
        chk("nouse_inport", {16'd0, ex_in_port_value}, 32'hBEEF);
        chk("nouse_insel", {31'd0, ex_in_port_select}, 32'd1);
        chk("nouse_count", {16'd0, bubble_count}, 32'd1);

        // Branch squash: two bubbles then D loads
        present(1'b1, 3'd2, 3'd4, 1'b1, 1'b1, 16'hD00D, 1'b1, 1'b0, 1'b0, 16'h0);
        branch_taken = 1'b1;
        #1;
        chk("br_fd_stall", {31'd0, fd_stall}, 32'd0);
        step();
        branch_taken = 1'b0;
        chk_bubble("br_bubble1");
        chk("br_count1", {16'd0, bubble_count}, 32'd2);
        step();
        chk_bubble("br_bubble2");
        chk("br_count2", {16'd0, bubble_count}, 32'd3);
        step();
        chk("br_load_valid", {31'd0, ex_valid}, 32'd1);
        chk("br_load_data1", {16'd0, ex_read_data1}, 32'hD00D);
        chk("br_count3", {16'd0, bubble_count}, 32'd3);

        // Stall during FLUSH with branch held: everything frozen
        branch_taken = 1'b1;
        step();
        chk("fs_count_enter", {16'd0, bubble_count}, 32'd4);
        ext_stall = 1'b1;
        present(1'b1, 3'd6, 3'd7, 1'b0, 1'b0, 16'hE0E0, 1'b1, 1'b0, 1'b0, 16'h0);
        #1;
        chk("fs_fd_stall", {31'd0, fd_stall}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_bubble("fs_frozen");
            chk("fs_count_frozen", {16'd0, bubble_count}, 32'd4);
        end
        ext_stall    = 1'b0;
        branch_taken = 1'b0;
        step();
        chk_bubble("fs_last_bubble");
        chk("fs_count_last", {16'd0, bubble_count}, 32'd5);
        step();
        chk("fs_run_valid", {31'd0, ex_valid}, 32'd1);
        chk("fs_run_data1", {16'd0, ex_read_data1}, 32'hE0E0);
        chk("fs_run_count", {16'd0, bubble_count}, 32'd5);

        // Stall with a valid instruction in EX: holds it
        ext_stall = 1'b1;
        present(1'b1, 3'd1, 3'd2, 1'b0, 1'b0, 16'hF00F, 1'b0, 1'b0, 1'b0, 16'h0);
        step();
        step();
        chk("st_hold_valid", {31'd0, ex_valid}, 32'd1);
        chk("st_hold_data1", {16'd0, ex_read_data1}, 32'hE0E0);
        chk("st_hold_rdest", {29'd0, ex_rdest}, 32'd7);
        ext_stall = 1'b0;
        step();
        chk("st_release_data1", {16'd0, ex_read_data1}, 32'hF00F);
        chk("st_release_rw", {31'd0, ex_reg_write}, 32'd0);

        // Reset in the middle of FLUSH
        branch_taken = 1'b1;
        step();
        branch_taken = 1'b0;
        rst = 1'b1;
        #1;
        chk_bubble("rst_flush");
        chk("rst_flush_count", {16'd0, bubble_count}, 32'd0);
        #2;
        rst = 1'b0;
        present(1'b1, 3'd0, 3'd6, 1'b0, 1'b0, 16'h7777, 1'b1, 1'b0, 1'b0, 16'h0);
        step();
        chk("rst_run_valid", {31'd0, ex_valid}, 32'd1);
        chk("rst_run_data1", {16'd0, ex_read_data1}, 32'h7777);
        chk("rst_run_count", {16'd0, bubble_count}, 32'd0);

        // Saturation: continuous branch yields one bubble per cycle
        present(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        branch_taken = 1'b1;
        repeat (65534) step();
        chk("sat_fffe", {16'd0, bubble_count}, 32'hFFFE);
        repeat (3) step();
        chk("sat_ffff", {16'd0, bubble_count}, 32'hFFFF);
        step();
        chk("sat_stay", {16'd0, bubble_count}, 32'hFFFF);
        branch_taken = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
